// File: rtl/vfu_slot_scheduler.sv
// Round-robin scheduler sharing one vector functional unit among several slots.
// One grant per cycle into a registered issue stage. A credit counter limits
// in-flight operations, and responses are routed back to slots by tag.
module vfu_slot_scheduler #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned TAG_W     = 2,
    parameter int unsigned REQ_W     = 190,
    parameter int unsigned RSP_W     = 33,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_SLOTS-1:0]       i_req_valid,
    output logic [NUM_SLOTS-1:0]       o_req_ready,
    input  logic [NUM_SLOTS*REQ_W-1:0] i_req_bits,
    output logic                       o_vfu_valid,
    input  logic                       i_vfu_ready,
    output logic [REQ_W-1:0]           o_vfu_bits,
    output logic [TAG_W-1:0]           o_vfu_tag,
    input  logic                       i_rsp_valid,
    input  logic [TAG_W-1:0]           i_rsp_tag,
    input  logic [RSP_W-1:0]           i_rsp_data,
    output logic [NUM_SLOTS-1:0]       o_slot_rsp_valid,
    output logic [RSP_W-1:0]           o_slot_rsp_data,
    output logic [3:0]                 o_inflight,
    output logic                       o_err
);

    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                 r_vfu_valid;
    logic [REQ_W-1:0]     r_vfu_bits;
    logic [TAG_W-1:0]     r_vfu_tag;
    logic [TAG_W-1:0]     r_ptr;
    logic [3:0]           r_inflight;
    logic                 r_err;

    logic                 w_can_load;
    logic                 w_credit_ok;
    logic                 w_grant;
    logic [TAG_W-1:0]     w_gidx;
    logic [REQ_W-1:0]     w_gbits;
    logic [REQ_W-1:0]     w_req_arr [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_req_ready;
    logic [NUM_SLOTS-1:0] w_slot_rsp_valid;
    logic                 w_rsp_dec;
    logic                 w_rsp_bad;

    // Issue register is empty or draining; responses this cycle do not free credit.
    assign w_can_load  = !r_vfu_valid || i_vfu_ready;
    assign w_credit_ok = r_inflight < 4'(MAX_OUT);

    // Unpack the flat payload bus into per-slot entries.
    always_comb begin
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            w_req_arr[i] = i_req_bits[i*REQ_W +: REQ_W];
        end
    end

    // Round-robin search from ptr+1; walking backwards lets the nearest slot win last.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_grant = 1'b0;
        w_gidx  = '0;
        w_gbits = '0;
        if (w_can_load && w_credit_ok) begin
            for (int unsigned k = NUM_SLOTS; k >= 1; k--) begin
                idx = (32'(r_ptr) + k) % NUM_SLOTS;
                if (i_req_valid[idx[IDX_W-1:0]]) begin
                    w_grant = 1'b1;
                    w_gidx  = TAG_W'(idx);
                    w_gbits = w_req_arr[idx[IDX_W-1:0]];
                end
            end
        end
    end

    // One-hot grant and tag-decoded response valid.
    always_comb begin
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            w_req_ready[i]      = w_grant && (w_gidx == TAG_W'(i));
            w_slot_rsp_valid[i] = i_rsp_valid && (32'(i_rsp_tag) == 32'(i));
        end
    end

    // Counter saturates at zero; a response with no credits or an out-of-range tag is an error.
    assign w_rsp_dec = i_rsp_valid && (r_inflight != 4'd0);
    assign w_rsp_bad = i_rsp_valid && ((r_inflight == 4'd0) || (32'(i_rsp_tag) >= NUM_SLOTS));

    // Issue register: load on grant, empty when drained with nothing new, else hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vfu_valid <= 1'b0;
            r_vfu_bits  <= '0;
            r_vfu_tag   <= '0;
            r_ptr       <= TAG_W'(NUM_SLOTS - 1);
        end else if (w_grant) begin
            r_vfu_valid <= 1'b1;
            r_vfu_bits  <= w_gbits;
            r_vfu_tag   <= w_gidx;
            r_ptr       <= w_gidx;
        end else if (i_vfu_ready) begin
            r_vfu_valid <= 1'b0;
        end
    end

    // Credit counter and sticky error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_grant && !w_rsp_dec) begin
                r_inflight <= r_inflight + 4'd1;
            end else if (!w_grant && w_rsp_dec) begin
                r_inflight <= r_inflight - 4'd1;
            end
            if (w_rsp_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_req_ready      = w_req_ready;
    assign o_vfu_valid      = r_vfu_valid;
    assign o_vfu_bits       = r_vfu_bits;
    assign o_vfu_tag        = r_vfu_tag;
    assign o_slot_rsp_valid = w_slot_rsp_valid;
    assign o_slot_rsp_data  = i_rsp_data;
    assign o_inflight       = r_inflight;
    assign o_err            = r_err;

endmodule

// File: tb/tb_vfu_slot_scheduler.sv
// Directed bench for vfu_slot_scheduler: a combinational vector table applied
// while reset holds the state fixed, then hand-written multi-cycle sequences.
module tb_vfu_slot_scheduler;

    localparam int NS = 4;
    localparam int RW = 190;
    localparam int DW = 33;

    logic             clk;
    logic             rst_n;
    logic [NS-1:0]    req_valid;
    logic [NS-1:0]    req_ready;
    logic [NS*RW-1:0] req_bits;
    logic             vfu_valid;
    logic             vfu_ready;
    logic [RW-1:0]    vfu_bits;
    logic [1:0]       vfu_tag;
    logic             rsp_valid;
    logic [1:0]       rsp_tag;
    logic [DW-1:0]    rsp_data;
    logic [NS-1:0]    slot_rsp_valid;
    logic [DW-1:0]    slot_rsp_data;
    logic [3:0]       inflight;
    logic             err;

    // Second instance: two slots with a 2-bit tag, for the out-of-range tag case.
    logic [1:0]  d2_req_valid;
    logic [1:0]  d2_req_ready;
    logic [15:0] d2_req_bits;
    logic        d2_vfu_valid;
    logic [7:0]  d2_vfu_bits;
    logic [1:0]  d2_vfu_tag;
    logic        d2_rsp_valid;
    logic [1:0]  d2_rsp_tag;
    logic [1:0]  d2_slot_rsp_valid;
    logic [7:0]  d2_slot_rsp_data;
    logic [3:0]  d2_inflight;
    logic        d2_err;

    int n_checks = 0;
    int n_errors = 0;

    vfu_slot_scheduler #(
        .NUM_SLOTS(4), .TAG_W(2), .REQ_W(RW), .RSP_W(DW), .MAX_OUT(4)
    ) u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_bits       (req_bits),
        .o_vfu_valid      (vfu_valid),
        .i_vfu_ready      (vfu_ready),
        .o_vfu_bits       (vfu_bits),
        .o_vfu_tag        (vfu_tag),
        .i_rsp_valid      (rsp_valid),
        .i_rsp_tag        (rsp_tag),
        .i_rsp_data       (rsp_data),
        .o_slot_rsp_valid (slot_rsp_valid),
        .o_slot_rsp_data  (slot_rsp_data),
        .o_inflight       (inflight),
        .o_err            (err)
    );

    vfu_slot_scheduler #(
        .NUM_SLOTS(2), .TAG_W(2), .REQ_W(8), .RSP_W(8), .MAX_OUT(4)
    ) u_dut2 (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (d2_req_valid),
        .o_req_ready      (d2_req_ready),
        .i_req_bits       (d2_req_bits),
        .o_vfu_valid      (d2_vfu_valid),
        .i_vfu_ready      (1'b1),
        .o_vfu_bits       (d2_vfu_bits),
        .o_vfu_tag        (d2_vfu_tag),
        .i_rsp_valid      (d2_rsp_valid),
        .i_rsp_tag        (d2_rsp_tag),
        .i_rsp_data       (8'h5A),
        .o_slot_rsp_valid (d2_slot_rsp_valid),
        .o_slot_rsp_data  (d2_slot_rsp_data),
        .o_inflight       (d2_inflight),
        .o_err            (d2_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]    req_valid;
        logic          rsp_valid;
        logic [1:0]    rsp_tag;
        logic [DW-1:0] rsp_data;
        logic [3:0]    exp_ready;
        logic [3:0]    exp_srv;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [RW-1:0] pay(int s);
        logic [191:0] t;
        t = {6{32'hC0DE_0000 + 32'(s) * 32'h0101}};
        return t[RW-1:0];
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        req_valid    = '0;
        vfu_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_tag      = '0;
        d2_req_valid = '0;
        d2_rsp_valid = 1'b0;
        d2_rsp_tag   = '0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int m_inflight;
        int m_next;
        int gslot;
        int gcount;
        bit g;
        bit r;

        for (int i = 0; i < NS; i++) req_bits[i*RW +: RW] = pay(i);
        d2_req_bits = 16'hB2A1;
        rsp_data    = '0;
        do_reset();
        rst_n = 1'b0;

        // Reset state
        chk("rst_vfu_valid", vfu_valid, 0);
        chk("rst_vfu_bits", vfu_bits, 0);
        chk("rst_vfu_tag", vfu_tag, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err", err, 0);

        // Combinational table, evaluated with reset held (ptr = 3, empty, no credits used)
        tbl[0] = '{4'b0000, 1'b0, 2'd0, 33'h0_0000_0000, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0001, 1'b1, 2'd0, 33'h1_2345_6789, 4'b0001, 4'b0001};
        tbl[2] = '{4'b0110, 1'b1, 2'd2, 33'h0_DEAD_BEEF, 4'b0010, 4'b0100};
        tbl[3] = '{4'b1000, 1'b1, 2'd3, 33'h1_FFFF_FFFF, 4'b1000, 4'b1000};
        tbl[4] = '{4'b1111, 1'b0, 2'd3, 33'h0_0000_0001, 4'b0001, 4'b0000};
        tbl[5] = '{4'b1100, 1'b1, 2'd1, 33'h1_0000_0000, 4'b0100, 4'b0010};
        tbl[6] = '{4'b1010, 1'b0, 2'd1, 33'h0_5555_AAAA, 4'b0010, 4'b0000};
        tbl[7] = '{4'b0100, 1'b1, 2'd3, 33'h0_1357_9BDF, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            req_valid = tbl[i].req_valid;
            rsp_valid = tbl[i].rsp_valid;
            rsp_tag   = tbl[i].rsp_tag;
            rsp_data  = tbl[i].rsp_data;
            #2;
            chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_slot_rsp_valid", i), slot_rsp_valid, tbl[i].exp_srv);
            chk($sformatf("tbl%0d_slot_rsp_data", i), slot_rsp_data, tbl[i].rsp_data);
        end

        // Reset then single request
        do_reset();
        req_valid = 4'b0001;
        vfu_ready = 1'b1;
        #1;
        chk("single_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        chk("single_vfu_valid", vfu_valid, 1);
        chk("single_vfu_tag", vfu_tag, 0);
        chk("single_vfu_bits", vfu_bits, pay(0));
        chk("single_inflight", inflight, 1);
        rsp_valid = 1'b1;
        rsp_tag   = 2'd0;
        #1;
        chk("single_rsp_route", slot_rsp_valid, 4'b0001);
        tick();
        rsp_valid = 1'b0;
        chk("single_inflight_after_rsp", inflight, 0);
        chk("single_vfu_drained", vfu_valid, 0);
        chk("single_err", err, 0);

        // Round-robin with all slots valid, one response per cycle after the 4th grant
        do_reset();
        req_valid  = 4'b1111;
        vfu_ready  = 1'b1;
        m_inflight = 0;
        m_next     = 0;
        for (int n = 0; n < 12; n++) begin
            r         = (n >= 4);
            rsp_valid = r;
            rsp_tag   = 2'(n);
            #1;
            g = (m_inflight < 4);
            chk($sformatf("rr%0d_ready", n), req_ready, g ? (4'b0001 << m_next) : 4'b0000);
            gslot = m_next;
            tick();
            if (g) begin
                chk($sformatf("rr%0d_tag", n), vfu_tag, gslot);
                chk($sformatf("rr%0d_bits", n), vfu_bits, pay(gslot));
                m_next = (m_next + 1) % 4;
            end
            m_inflight = m_inflight + (g ? 1 : 0) - ((r && m_inflight > 0) ? 1 : 0);
            chk($sformatf("rr%0d_inflight", n), inflight, m_inflight);
        end
        rsp_valid = 1'b0;
        req_valid = 4'b0000;

        // Backpressure: slot 1 issued then frozen while the VFU stalls
        do_reset();
        req_valid = 4'b0110;
        vfu_ready = 1'b0;
        #1;
        chk("bp_first_grant", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0100;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("bp%0d_ready", n), req_ready, 4'b0000);
            chk($sformatf("bp%0d_valid", n), vfu_valid, 1);
            chk($sformatf("bp%0d_tag", n), vfu_tag, 1);
            chk($sformatf("bp%0d_bits", n), vfu_bits, pay(1));
            tick();
        end
        vfu_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        chk("bp_release_tag", vfu_tag, 2);
        chk("bp_release_bits", vfu_bits, pay(2));
        chk("bp_release_inflight", inflight, 2);

        // Credit limit: four grants then stall until a response returns a credit
        do_reset();
        req_valid = 4'b0001;
        vfu_ready = 1'b1;
        gcount    = 0;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (req_ready[0]) gcount++;
            tick();
        end
        chk("credit_grants", gcount, 4);
        chk("credit_inflight", inflight, 4);
        chk("credit_stall_ready", req_ready, 4'b0000);
        rsp_valid = 1'b1;
        rsp_tag   = 2'd0;
        #1;
        chk("credit_same_cycle_ready", req_ready, 4'b0000);
        chk("credit_rsp_route", slot_rsp_valid, 4'b0001);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("credit_freed_inflight", inflight, 3);
        chk("credit_freed_ready", req_ready, 4'b0001);
        tick();
        chk("credit_refill_inflight", inflight, 4);

        // Reset mid-operation clears immediately; the stale response then flags an error
        rst_n = 1'b0;
        #1;
        chk("midrst_inflight", inflight, 0);
        chk("midrst_vfu_valid", vfu_valid, 0);
        req_valid = 4'b0000;
        tick();
        rst_n     = 1'b1;
        rsp_valid = 1'b1;
        rsp_tag   = 2'd0;
        tick();
        rsp_valid = 1'b0;
        chk("stale_rsp_err", err, 1);
        chk("stale_rsp_inflight", inflight, 0);
        tick();
        chk("err_sticky", err, 1);

        // Simultaneous grant and response at inflight = 2
        do_reset();
        chk("err_cleared", err, 0);
        req_valid = 4'b0001;
        vfu_ready = 1'b1;
        tick();
        tick();
        chk("sim_pre_inflight", inflight, 2);
        rsp_valid = 1'b1;
        rsp_tag   = 2'd2;
        #1;
        chk("sim_ready", req_ready, 4'b0001);
        chk("sim_route", slot_rsp_valid, 4'b0100);
        tick();
        rsp_valid = 1'b0;
        req_valid = 4'b0000;
        chk("sim_inflight", inflight, 2);
        chk("sim_err", err, 0);

        // Two-slot instance: tag 3 is out of range
        do_reset();
        d2_req_valid = 2'b01;
        #1;
        chk("d2_grant", d2_req_ready, 2'b01);
        tick();
        d2_req_valid = 2'b00;
        chk("d2_inflight_one", d2_inflight, 1);
        chk("d2_vfu_bits", d2_vfu_bits, 8'hA1);
        d2_rsp_valid = 1'b1;
        d2_rsp_tag   = 2'd3;
        #1;
        chk("d2_bad_tag_route", d2_slot_rsp_valid, 2'b00);
        tick();
        d2_rsp_valid = 1'b0;
        chk("d2_bad_tag_err", d2_err, 1);
        chk("d2_bad_tag_inflight", d2_inflight, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vfu_slot_scheduler.md
# vfu_slot_scheduler

Round-robin scheduler that shares one vector functional unit (VFU) among the lane's execution slots. Each slot presents a packed SlotRequestToVFU payload on a ready/valid port. The scheduler grants one slot per cycle into a registered issue stage, stamps the request tag with the slot index, and limits in-flight operations with a credit counter. VFU responses are routed back to the originating slot by tag. It sits between the lane slot pipelines and the shared VFU, replacing a single-input pass-through arbiter when more than one slot shares the unit.

## Interface
Parameters:
- NUM_SLOTS, 4: number of requesting slots (power of two, 2..8)
- TAG_W, 2: tag width, equal to log2(NUM_SLOTS)
- REQ_W, 190: packed request payload width, tag excluded
- RSP_W, 33: response data width
- MAX_OUT, 4: maximum in-flight requests (1..15)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- req_valid  in  NUM_SLOTS  per-slot request valid
- req_ready  out  NUM_SLOTS  per-slot grant/accept
- req_bits  in  NUM_SLOTS*REQ_W  payloads; slot i occupies bits [i*REQ_W +: REQ_W]
- vfu_valid  out  1  issue register valid
- vfu_ready  in  1  VFU accepts the issued request
- vfu_bits  out  REQ_W  issued payload
- vfu_tag  out  TAG_W  index of the slot that issued the request
- rsp_valid  in  1  VFU response valid (no backpressure)
- rsp_tag  in  TAG_W  response tag
- rsp_data  in  RSP_W  response data
- slot_rsp_valid  out  NUM_SLOTS  one-hot decoded response valid
- slot_rsp_data  out  RSP_W  response data, broadcast to all slots
- inflight  out  4  current credit usage
- err  out  1  sticky protocol-error flag

## Operation
- can_load = !vfu_valid || vfu_ready. This is the issue register's empty-or-draining condition.
- credit_ok = inflight < MAX_OUT. Same-cycle responses do not free a credit for arbitration.
- Arbitration runs only when can_load && credit_ok.
  - Search order is ptr+1, ptr+2, … modulo NUM_SLOTS.
  - The first slot with req_valid high wins.
- req_ready[i] is high only for the granted slot. At most one bit is set, and it is combinational from req_valid, vfu_ready and state.
- On grant g:
  - vfu_bits <= req_bits[g]
  - vfu_tag <= g
  - vfu_valid <= 1
  - ptr <= g
- No grant while can_load: vfu_valid <= 0 when vfu_ready. The issue register holds otherwise; bits and tag stay stable while vfu_valid && !vfu_ready.
- inflight update, per cycle:
  - +1 on grant
  - −1 on rsp_valid
  - Both in the same cycle: unchanged.
  - The count covers the request held in the issue register plus requests accepted by the VFU and not yet answered.
- Response routing:
  - slot_rsp_valid = rsp_valid ? onehot(rsp_tag) : 0
  - slot_rsp_data = rsp_data
  - Both are purely combinational.
- err is set, and never cleared except by reset, on either of:
  - rsp_valid with inflight == 0 (the counter saturates at 0);
  - rsp_valid with rsp_tag >= NUM_SLOTS (slot_rsp_valid = 0, inflight still decremented).

## Timing
- Reset values:
  - vfu_valid = 0, vfu_bits = 0, vfu_tag = 0
  - inflight = 0, err = 0
  - ptr = NUM_SLOTS−1, so slot 0 has first priority after reset
  - req_ready is 0 whenever all req_valid are low.
- Issue latency is 1 cycle: a grant in cycle N gives vfu_valid high in cycle N+1.
- Full throughput: with vfu_ready held high and credits available, one grant per cycle back to back.
- Backpressure: while vfu_valid && !vfu_ready, no grants occur and the register contents are frozen.
- Response path latency is 0 cycles.
- Reset asserted mid-operation: everything clears immediately. An in-flight VFU op is forgotten, and its later response sets err.
- Fairness: a continuously valid slot is granted within NUM_SLOTS grants.

## Test plan
- Reset then single request:
  - reset low 3 cycles, then req_valid = 0001, vfu_ready = 1.
  - Expect req_ready = 0001 in the same cycle, and in the next cycle vfu_valid = 1, vfu_tag = 0, vfu_bits = slot 0 payload, inflight = 1.
- Round-robin:
  - all four slots valid, vfu_ready = 1, MAX_OUT = 4, one response per cycle starting after the 4th grant.
  - Expect grant order 0, 1, 2, 3, 0, 1 …, with no slot granted twice before the others.
- Backpressure:
  - vfu_ready = 0 for 5 cycles with slots 1 and 2 valid.
  - Expect the issue register holding slot 1's payload and tag 1 unchanged for all 5 cycles and req_ready = 0.
  - After vfu_ready = 1, slot 2 is granted in the same cycle and issued next cycle.
- Credit limit:
  - MAX_OUT = 4, no responses, slot 0 continuously valid.
  - Expect exactly 4 grants, inflight = 4, then req_ready = 0.
  - One rsp_valid with tag 0 gives inflight = 3 the next cycle, and a grant the cycle after that response.
- Simultaneous grant and response at inflight = 2: expect inflight stays 2 and slot_rsp_valid = onehot(rsp_tag) in the same cycle.
- Error cases:
  - rsp_valid with inflight = 0: expect err = 1 and inflight stays 0.
  - NUM_SLOTS = 2, TAG_W = 2, rsp_tag = 3 with inflight = 1: expect slot_rsp_valid = 00, err = 1, inflight = 0.
